// File: rtl/hub75_rx.sv
// HUB75 receiver: synchronizes mat_* lines, rebuilds latched rows and streams them as pixel words.
// pix_valid rises SYNC_STAGES+1 clk edges after mat_lat is first sampled high; words hold while pix_ready is low.
module hub75_rx #(
  parameter int WIDTH       = 64,
  parameter int ROW_BITS    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mat_r,
  input  logic [1:0]               mat_g,
  input  logic [1:0]               mat_b,
  input  logic [ROW_BITS-1:0]      mat_row,
  input  logic                     mat_clk,
  input  logic                     mat_lat,
  input  logic                     mat_oe,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic [ROW_BITS-1:0]      pix_row,
  output logic [$clog2(WIDTH)-1:0] pix_col,
  output logic [5:0]               pix_data,
  output logic                     row_done,
  output logic [7:0]               last_len,
  output logic                     overflow,
  output logic                     disp_on
);
  localparam int COLW = $clog2(WIDTH);
  localparam int IW   = 9 + ROW_BITS;

  typedef enum logic {IDLE, EMIT} state_t;

  logic [IW-1:0]       sync_q [SYNC_STAGES];
  logic [IW-1:0]       in_vec;
  logic [IW-1:0]       s_last;
  logic [5:0]          s_rgb;
  logic [ROW_BITS-1:0] s_row;
  logic                s_clk, s_lat;
  logic                prev_clk, prev_lat;
  logic                clk_rise, lat_rise;
  logic [5:0]          shreg    [WIDTH];
  logic [5:0]          shreg_nx [WIDTH];
  logic [5:0]          hold     [WIDTH];
  logic [7:0]          cnt, cnt_nx;
  state_t              state;

  // All lines go through the same synchronizer depth so row/rgb stay aligned with clk/lat edges.
  assign in_vec   = {mat_oe, mat_lat, mat_clk, mat_row, mat_b, mat_g, mat_r};
  assign s_last   = sync_q[SYNC_STAGES-1];
  assign s_rgb    = s_last[5:0];
  assign s_row    = s_last[6 +: ROW_BITS];
  assign s_clk    = s_last[6+ROW_BITS];
  assign s_lat    = s_last[7+ROW_BITS];
  assign disp_on  = s_last[8+ROW_BITS];
  assign clk_rise = s_clk & ~prev_clk;
  assign lat_rise = s_lat & ~prev_lat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_clk <= 1'b0;
      prev_lat <= 1'b0;
    end else begin
      sync_q[0] <= in_vec;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_clk <= s_clk;
      prev_lat <= s_lat;
    end
  end

  // Next shift-register image; a latch commits this so a coincident mat_clk pixel is included.
  always_comb begin
    shreg_nx[0] = clk_rise ? s_rgb : shreg[0];
    for (int k = 1; k < WIDTH; k++) shreg_nx[k] = clk_rise ? shreg[k-1] : shreg[k];
  end

  always_comb begin
    cnt_nx = cnt;
    if (clk_rise && cnt != 8'hFF) cnt_nx = cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < WIDTH; k++) shreg[k] <= '0;
      cnt      <= '0;
      last_len <= '0;
    end else begin
      for (int k = 0; k < WIDTH; k++) shreg[k] <= shreg_nx[k];
      if (lat_rise) begin
        last_len <= cnt_nx;
        cnt      <= '0;
      end else begin
        cnt <= cnt_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < WIDTH; k++) hold[k] <= '0;
      state     <= IDLE;
      pix_valid <= 1'b0;
      pix_row   <= '0;
      pix_col   <= '0;
      pix_data  <= '0;
      row_done  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      row_done <= 1'b0;
      case (state)
        IDLE: begin
          if (lat_rise) begin
            for (int k = 0; k < WIDTH; k++) hold[k] <= shreg_nx[k];
            pix_row   <= s_row;
            pix_col   <= '0;
            pix_data  <= shreg_nx[0];
            pix_valid <= 1'b1;
            state     <= EMIT;
          end
        end
        EMIT: begin
          if (lat_rise) overflow <= 1'b1;
          if (pix_ready) begin
            if (pix_col == COLW'(WIDTH-1)) begin
              state     <= IDLE;
              pix_valid <= 1'b0;
              pix_col   <= '0;
              pix_data  <= '0;
              row_done  <= 1'b1;
            end else begin
              pix_col  <= pix_col + COLW'(1);
              pix_data <= hold[pix_col + COLW'(1)];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hub75_rx.sv
// Directed bench for hub75_rx: drives HUB75 lines, checks emitted rows against a shift-register model.
module tb_hub75_rx;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mat_r, mat_g, mat_b;
  logic [3:0] mat_row;
  logic       mat_clk, mat_lat, mat_oe;
  logic       pix_valid, pix_ready;
  logic [3:0] pix_row;
  logic [5:0] pix_col;
  logic [5:0] pix_data;
  logic       row_done;
  logic [7:0] last_len;
  logic       overflow, disp_on;

  int checks = 0;
  int failures = 0;
  int first_valid_c;
  int nw;
  int cnt_m = 0;
  int exp_len;
  logic [3:0] exp_row;
  logic [5:0] mdl [64];
  logic [5:0] exp_hold [64];

  hub75_rx dut (
    .clk(clk), .rst(rst), .mat_r(mat_r), .mat_g(mat_g), .mat_b(mat_b),
    .mat_row(mat_row), .mat_clk(mat_clk), .mat_lat(mat_lat), .mat_oe(mat_oe),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_row(pix_row),
    .pix_col(pix_col), .pix_data(pix_data), .row_done(row_done),
    .last_len(last_len), .overflow(overflow), .disp_on(disp_on)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_shift(input logic [5:0] v);
    for (int k = 63; k > 0; k--) mdl[k] = mdl[k-1];
    mdl[0] = v;
    if (cnt_m < 255) cnt_m++;
  endtask

  task automatic drive_rgb(input logic [5:0] v);
    mat_r = v[1:0];
    mat_g = v[3:2];
    mat_b = v[5:4];
  endtask

  task automatic shift_px(input logic [5:0] v);
    drive_rgb(v);
    mat_clk = 1'b0;
    repeat (2) step();
    mat_clk = 1'b1;
    repeat (2) step();
    mat_clk = 1'b0;
    model_shift(v);
  endtask

  // Runs one emission window; mat_lat (and a coincident mat_clk) must already be high on entry.
  task automatic run_emit(input int rmode, input int lat2_at, input int abort_col, output int nwords);
    int done_cnt, after, lat_off;
    logic stalled;
    logic [31:0] s_col, s_dat, s_row;
    nwords = 0; done_cnt = 0; after = -1; lat_off = -1; stalled = 1'b0;
    s_col = '0; s_dat = '0; s_row = '0;
    first_valid_c = -1;
    for (int c = 0; c < 800; c++) begin
      step();
      if (c == 3) begin
        mat_lat = 1'b0;
        mat_clk = 1'b0;
      end
      if (c == lat_off) mat_lat = 1'b0;
      if (first_valid_c < 0 && pix_valid) first_valid_c = c;
      if (row_done) begin
        done_cnt++;
        chk("row_done_after_col63", nwords, 64);
      end
      if (stalled) begin
        chk("stall_valid", 32'(pix_valid), 1);
        chk("stall_col", 32'(pix_col), s_col);
        chk("stall_data", 32'(pix_data), s_dat);
        chk("stall_row", 32'(pix_row), s_row);
        stalled = 1'b0;
      end
      if (abort_col >= 0 && pix_valid && pix_col == 6'(abort_col)) begin
        rst = 1'b0;
        #1;
        chk("abort_valid", 32'(pix_valid), 0);
        chk("abort_col", 32'(pix_col), 0);
        chk("abort_data", 32'(pix_data), 0);
        chk("abort_row", 32'(pix_row), 0);
        chk("abort_last_len", 32'(last_len), 0);
        chk("abort_overflow", 32'(overflow), 0);
        chk("abort_disp_on", 32'(disp_on), 0);
        chk("abort_row_done", 32'(row_done), 0);
        chk("abort_done_count", done_cnt, 0);
        return;
      end
      pix_ready = (rmode == 0) ? 1'b1 : ~pix_ready;
      if (pix_valid && pix_ready) begin
        chk("word_col", 32'(pix_col), nwords);
        chk("word_data", 32'(pix_data), 32'(exp_hold[nwords & 63]));
        chk("word_row", 32'(pix_row), 32'(exp_row));
        nwords++;
        if (nwords == lat2_at) begin
          mat_lat = 1'b1;
          lat_off = c + 4;
        end
      end else if (pix_valid) begin
        stalled = 1'b1;
        s_col = 32'(pix_col);
        s_dat = 32'(pix_data);
        s_row = 32'(pix_row);
      end
      if (done_cnt > 0 && after < 0) after = c + 20;
      if (c == after) break;
    end
    chk("row_done_once", done_cnt, 1);
  endtask

  task automatic latch_emit(input logic [3:0] row, input int rmode, input int lat2_at,
                            input int abort_col, input bit coin, input logic [5:0] cv,
                            output int nwords);
    if (coin) begin
      drive_rgb(cv);
      mat_clk = 1'b1;
      model_shift(cv);
    end
    for (int k = 0; k < 64; k++) exp_hold[k] = mdl[k];
    exp_len = cnt_m;
    cnt_m = 0;
    exp_row = row;
    mat_row = row;
    mat_lat = 1'b1;
    run_emit(rmode, lat2_at, abort_col, nwords);
  endtask

  initial begin
    rst = 1'b0;
    mat_r = '0; mat_g = '0; mat_b = '0; mat_row = '0;
    mat_clk = 1'b0; mat_lat = 1'b0; mat_oe = 1'b0; pix_ready = 1'b0;
    for (int k = 0; k < 64; k++) mdl[k] = '0;
    repeat (3) step();
    chk("rst_valid", 32'(pix_valid), 0);
    chk("rst_row_done", 32'(row_done), 0);
    chk("rst_last_len", 32'(last_len), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_disp_on", 32'(disp_on), 0);
    chk("rst_col", 32'(pix_col), 0);
    chk("rst_data", 32'(pix_data), 0);
    rst = 1'b1;
    step();

    mat_oe = 1'b1;
    repeat (4) step();
    chk("disp_on_high", 32'(disp_on), 1);
    chk("oe_no_emit", 32'(pix_valid), 0);
    mat_oe = 1'b0;
    repeat (4) step();
    chk("disp_on_low", 32'(disp_on), 0);

    // Full row, column index as pixel value
    for (int i = 0; i < 64; i++) shift_px(6'(i));
    latch_emit(4'd5, 0, -1, -1, 1'b0, 6'h0, nw);
    chk("t1_words", nw, 64);
    chk("t1_col0_is_last_shifted", 32'(exp_hold[0]), 32'h3F);
    chk("t1_last_len", 32'(last_len), 64);
    chk("t1_latency", first_valid_c, 2);
    chk("t1_overflow", 32'(overflow), 0);

    // Row of 0x3F, then a short row over it with a stalling consumer
    for (int i = 0; i < 64; i++) shift_px(6'h3F);
    latch_emit(4'd1, 0, -1, -1, 1'b0, 6'h0, nw);
    chk("t2a_words", nw, 64);
    chk("t2a_last_len", 32'(last_len), 64);
    for (int i = 0; i < 10; i++) shift_px(6'((i * 7 + 1) & 63));
    latch_emit(4'd2, 1, -1, -1, 1'b0, 6'h0, nw);
    chk("t2b_words", nw, 64);
    chk("t2b_last_len", 32'(last_len), 10);
    chk("t2b_col10_old", 32'(exp_hold[10]), 32'h3F);

    // Second latch five words into emission
    for (int i = 0; i < 3; i++) shift_px(6'(i + 40));
    latch_emit(4'd3, 0, 5, -1, 1'b0, 6'h0, nw);
    chk("t4_words", nw, 64);
    chk("t4_overflow", 32'(overflow), 1);
    chk("t4_last_len_second", 32'(last_len), 0);
    chk("t4_no_second_row", 32'(pix_valid), 0);
    repeat (10) step();
    chk("t4_overflow_sticky", 32'(overflow), 1);

    // mat_clk and mat_lat rising together
    shift_px(6'h11);
    shift_px(6'h22);
    repeat (2) step();
    latch_emit(4'd6, 0, -1, -1, 1'b1, 6'h2B, nw);
    chk("t5_words", nw, 64);
    chk("t5_col0_new_px", 32'(exp_hold[0]), 32'h2B);
    chk("t5_last_len", 32'(last_len), 3);

    // Reset in the middle of emission
    for (int i = 0; i < 4; i++) shift_px(6'(i + 50));
    latch_emit(4'd7, 0, -1, 20, 1'b0, 6'h0, nw);
    chk("t6_abort_words", nw, 20);
    repeat (3) begin
      step();
      chk("t6_hold_rst_done", 32'(row_done), 0);
    end
    rst = 1'b1;
    for (int k = 0; k < 64; k++) mdl[k] = '0;
    cnt_m = 0;
    step();
    chk("t6_post_rst_valid", 32'(pix_valid), 0);
    shift_px(6'h2A);
    shift_px(6'h15);
    latch_emit(4'd9, 0, -1, -1, 1'b0, 6'h0, nw);
    chk("t6_words", nw, 64);
    chk("t6_last_len", 32'(last_len), 2);
    chk("t6_overflow", 32'(overflow), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
